// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: rx state encoding, register
// addresses and status/control bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [1:0] REG_DATA    = 2'b00;
    localparam logic [1:0] REG_STATUS  = 2'b01;
    localparam logic [1:0] REG_CONTROL = 2'b10;

    localparam int STAT_AVAIL     = 0;
    localparam int STAT_BUSY      = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_FULL      = 4;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO with wrap-around pointers and a combinational head read.
// Pops on empty are ignored; a push while full is accepted only alongside a pop.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Stale storage is never exposed: an empty buffer reads as zero.
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with data/status/control register interface.
// Define UART_RX_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIVISOR   = 208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       writeEnable,
    input  logic       readEnable,
    input  logic [1:0] regSelect,
    input  logic [7:0] writeData,
    output logic [7:0] Data,
    output logic       rxReady
);
    localparam int CNT_W = $clog2(DIVISOR);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta_reg;
    logic                 rx_sync_reg;
    logic                 rx_prev_reg;
    rx_state_t            state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [BIT_W-1:0]     bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [7:0]           control_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;

    logic                 enable;
    logic                 stop_sample;
    logic                 push;
    logic                 pop;
    logic                 pop_eff;
    logic                 flush;
    logic                 status_wr;
    logic [DATA_BITS-1:0] buf_head;
    logic                 buf_empty;
    logic                 buf_full;
    logic [7:0]           status_vec;

    assign enable      = control_reg[CTRL_ENABLE];
    assign stop_sample = enable && (state_reg == RX_STOP) && (cnt_reg == FULL_LAST);
    assign push        = stop_sample && rx_sync_reg;
    assign pop         = readEnable && (regSelect == REG_DATA);
    assign pop_eff     = pop && !buf_empty;
    assign flush       = writeEnable && (regSelect == REG_CONTROL) && writeData[CTRL_FLUSH];
    assign status_wr   = writeEnable && (regSelect == REG_STATUS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else if (!enable) begin
            // Disabling the receiver abandons any frame in progress.
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
        end else begin
            case (state_reg)
                RX_IDLE: begin
                    cnt_reg     <= '0;
                    bit_idx_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg)
                        state_reg <= RX_START;
                end
                RX_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= DATA_BITS'({rx_sync_reg, shift_reg} >> 1);
                        if (bit_idx_reg == BIT_LAST)
                            state_reg <= RX_STOP;
                        else
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= RX_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            control_reg   <= 8'h00;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (writeEnable && (regSelect == REG_CONTROL))
                control_reg <= writeData & ~(8'h01 << CTRL_FLUSH);
            // A new error event wins over a simultaneous clear.
            if (stop_sample && !rx_sync_reg)
                frame_err_reg <= 1'b1;
            else if (status_wr && writeData[STAT_FRAME_ERR])
                frame_err_reg <= 1'b0;
            if (push && buf_full && !pop_eff && !flush)
                overrun_reg <= 1'b1;
            else if (status_wr && writeData[STAT_OVERRUN])
                overrun_reg <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .DEPTH (4),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (shift_reg),
        .head  (buf_head),
        .empty (buf_empty),
        .full  (buf_full)
    );
`else
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_valid_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
        end else if (flush) begin
            hold_valid_reg <= 1'b0;
        end else if (push && (!hold_valid_reg || pop)) begin
            hold_reg       <= shift_reg;
            hold_valid_reg <= 1'b1;
        end else if (pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    assign buf_head  = hold_valid_reg ? hold_reg : '0;
    assign buf_empty = !hold_valid_reg;
    assign buf_full  = hold_valid_reg;
`endif

    always_comb begin
        status_vec                 = 8'h00;
        status_vec[STAT_AVAIL]     = !buf_empty;
        status_vec[STAT_BUSY]      = (state_reg != RX_IDLE);
        status_vec[STAT_FRAME_ERR] = frame_err_reg;
        status_vec[STAT_OVERRUN]   = overrun_reg;
        status_vec[STAT_FULL]      = buf_full;
    end

    always_comb begin
        Data = 8'h00;
        case (regSelect)
            REG_DATA:    Data = 8'(buf_head);
            REG_STATUS:  Data = status_vec;
            REG_CONTROL: Data = control_reg;
            default:     Data = 8'h00;
        endcase
    end

    assign rxReady = !buf_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: random frames against a queue-based model
// of the receive buffer and sticky error flags (DIVISOR=16).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int D  = 16;
    localparam int NB = 8;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       writeEnable = 1'b0;
    logic       readEnable = 1'b0;
    logic [1:0] regSelect = 2'b00;
    logic [7:0] writeData = 8'h00;
    logic [7:0] Data;
    logic       rxReady;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mq[$];
    bit         m_fe = 1'b0;
    bit         m_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.DATA_BITS(NB), .DIVISOR(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .writeEnable (writeEnable),
        .readEnable  (readEnable),
        .regSelect   (regSelect),
        .writeData   (writeData),
        .Data        (Data),
        .rxReady     (rxReady)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'h00;
        s[0] = (mq.size() != 0);
        s[2] = m_fe;
        s[3] = m_ovr;
        s[4] = (mq.size() == DEPTH);
        return s;
    endfunction

    task automatic m_frame(input logic [7:0] b, input bit stop);
        if (!stop)
            m_fe = 1'b1;
        else if (mq.size() < DEPTH)
            mq.push_back(b);
        else
            m_ovr = 1'b1;
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [7:0] val);
        @(negedge clk);
        regSelect = sel; writeData = val; writeEnable = 1'b1;
        @(negedge clk);
        writeEnable = 1'b0;
        $display("write sel=%0d data=%h", sel, val);
    endtask

    task automatic reg_read(input logic [1:0] sel, input bit pop, output logic [7:0] val);
        @(negedge clk);
        regSelect = sel; readEnable = pop;
        #1 val = Data;
        @(negedge clk);
        readEnable = 1'b0;
        $display("read  sel=%0d pop=%0d data=%h", sel, pop, val);
    endtask

    // Called at a falling clock edge; bit cells are D cycles long, one idle cell after.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            rx = b[i];
            repeat (D) @(negedge clk);
        end
        rx = stop;
        repeat (D) @(negedge clk);
        rx = 1'b1;
        repeat (D) @(negedge clk);
        $display("frame byte=%h stop=%0d", b, stop);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            reg_read(2'(s), 1'b0, v);
            n_cmp++;
            if (v !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_reg%0d: got %h expected 00", s, v);
            end
        end
        n_cmp++;
        if (rxReady !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rxready: got %b expected 0", rxReady);
        end
        reset = 1'b1;
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== 8'h00) begin
            n_bad++;
            $display("FAIL post_reset_status: got %h expected 00", v);
        end
    endtask

    task automatic test_basic();
        logic [7:0] v;
        int cyc;
        reg_write(REG_CONTROL, 8'h01);
        cyc = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!rxReady && cyc < 12 * D) begin
                    @(posedge clk);
                    #1 cyc++;
                end
            end
        join
        m_frame(8'hA5, 1'b1);
        n_cmp++;
        if (cyc < D / 2 + 9 * D - 2 || cyc > D / 2 + 9 * D + 6) begin
            n_bad++;
            $display("FAIL basic_ready_latency: got %0d cycles expected %0d..%0d",
                     cyc, D / 2 + 9 * D - 2, D / 2 + 9 * D + 6);
        end
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL basic_status: got %h expected %h", v, m_status());
        end
        reg_read(REG_DATA, 1'b1, v);
        n_cmp++;
        if (v !== mq[0]) begin
            n_bad++;
            $display("FAIL basic_data: got %h expected %h", v, mq[0]);
        end
        void'(mq.pop_front());
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL basic_after_pop: got %h expected %h", v, m_status());
        end
    endtask

    task automatic test_framing();
        logic [7:0] v;
        send_frame(8'h3C, 1'b0);
        m_frame(8'h3C, 1'b0);
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL framing_status: got %h expected %h", v, m_status());
        end
        reg_write(REG_STATUS, 8'h04);
        m_fe = 1'b0;
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL framing_clear: got %h expected %h", v, m_status());
        end
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        logic [7:0] e;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i * 8'h11), 1'b1);
            m_frame(8'(i * 8'h11), 1'b1);
        end
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL overrun_status: got %h expected %h", v, m_status());
        end
        while (mq.size() != 0) begin
            e = mq.pop_front();
            reg_read(REG_DATA, 1'b1, v);
            n_cmp++;
            if (v !== e) begin
                n_bad++;
                $display("FAIL overrun_drain: got %h expected %h", v, e);
            end
        end
        reg_write(REG_STATUS, 8'h08);
        m_ovr = 1'b0;
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL overrun_clear: got %h expected %h", v, m_status());
        end
    endtask

    task automatic test_false_start();
        logic [7:0] v;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL false_start_busy: got %b expected 1", v[1]);
        end
        repeat (2 * D) @(negedge clk);
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL false_start_status: got %h expected %h", v, m_status());
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [7:0] b;
        bit stop;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            m_frame(b, stop);
            reg_read(REG_STATUS, 1'b0, v);
            n_cmp++;
            if (v !== m_status()) begin
                n_bad++;
                $display("FAIL random_status%0d: got %h expected %h", i, v, m_status());
            end
            if ($urandom_range(0, 1) == 1 && mq.size() != 0) begin
                reg_read(REG_DATA, 1'b1, v);
                n_cmp++;
                if (v !== mq[0]) begin
                    n_bad++;
                    $display("FAIL random_data%0d: got %h expected %h", i, v, mq[0]);
                end
                void'(mq.pop_front());
            end
            if ($urandom_range(0, 2) == 0) begin
                reg_write(REG_STATUS, 8'h0C);
                m_fe = 1'b0;
                m_ovr = 1'b0;
            end
        end
        while (mq.size() != 0) begin
            reg_read(REG_DATA, 1'b1, v);
            n_cmp++;
            if (v !== mq[0]) begin
                n_bad++;
                $display("FAIL random_drain: got %h expected %h", v, mq[0]);
            end
            void'(mq.pop_front());
        end
        reg_write(REG_STATUS, 8'h0C);
        m_fe = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v;
        rx = 1'b0;
        repeat (D) @(negedge clk);
        rx = 1'b1;
        repeat (3 * D) @(negedge clk);
        reset = 1'b0;
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset_status: got %h expected 00", v);
        end
        reset = 1'b1;
        mq.delete();
        m_fe = 1'b0;
        m_ovr = 1'b0;
        repeat (6 * D) @(negedge clk);
        reg_write(REG_CONTROL, 8'h01);
        send_frame(8'h81, 1'b1);
        m_frame(8'h81, 1'b1);
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL midreset_after_status: got %h expected %h", v, m_status());
        end
        reg_read(REG_DATA, 1'b1, v);
        n_cmp++;
        if (v !== 8'h81) begin
            n_bad++;
            $display("FAIL midreset_data: got %h expected 81", v);
        end
        void'(mq.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic [7:0] b1;
        logic [7:0] b2;
        bit got;
        int cyc;
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        send_frame(b1, 1'b1);
        m_frame(b1, 1'b1);
        got = 1'b0;
        fork
            send_frame(b2, 1'b1);
            begin
                regSelect = REG_STATUS;
                cyc = 0;
                while (!got && cyc < 4 * D) begin
                    @(posedge clk);
                    #1 if (Data[1]) got = 1'b1;
                    cyc++;
                end
                if (got) begin
                    // Stop sample lands D/2 + (NB+1)*D cycles after entering the start state.
                    repeat (D / 2 + (NB + 1) * D - 1) @(posedge clk);
                    @(negedge clk);
                    regSelect = REG_DATA;
                    readEnable = 1'b1;
                    #1 v = Data;
                    @(posedge clk);
                    #1 readEnable = 1'b0;
                    regSelect = REG_STATUS;
                    n_cmp++;
                    if (v !== b1) begin
                        n_bad++;
                        $display("FAIL b2b_pop_data: got %h expected %h", v, b1);
                    end
                end
            end
        join
        n_cmp++;
        if (got !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_busy_seen: got %b expected 1", got);
        end
        void'(mq.pop_front());
        m_frame(b2, 1'b1);
        reg_read(REG_STATUS, 1'b0, v);
        n_cmp++;
        if (v !== m_status()) begin
            n_bad++;
            $display("FAIL b2b_status: got %h expected %h", v, m_status());
        end
        reg_read(REG_DATA, 1'b0, v);
        n_cmp++;
        if (v !== b2) begin
            n_bad++;
            $display("FAIL b2b_head: got %h expected %h", v, b2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_framing();
        test_overrun();
        test_false_start();
        test_random();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
